clk_div_sched: RTL and testbench
================================

Name: clk_div_sched

Overview:
Central divided-clock scheduler. It owns one free-running 4-bit divide counter and serves N_CH consumer channels. Each channel gets a registered divided clock (÷2/÷4/÷8/÷16) and a one-cycle clock-enable strobe. Requesters change their channel's rate through a req/ack handshake; a round-robin arbiter serialises the requests, and a change is applied only at a counter wrap so no runt pulses occur.

Parameters:
N_CH, 4, number of scheduled channels (1..8)
RESET_RATE, 2'd0, rate code loaded into every channel at reset (0=÷2, 1=÷4, 2=÷8, 3=÷16)

Ports:
iClkIN  in  1  single clock; all logic on posedge
reset  in  1  asynchronous, active-high reset
iEn  in  1  counter run enable; when 0 the counter holds
iSync  in  1  synchronous counter clear (counter<=0 next edge); takes priority over iEn
iReq  in  N_CH  per-channel rate-change request, level, held until oAck
iRate  in  2*N_CH  requested rate code, channel i at [2i+1:2i]; must be stable while iReq[i]=1
oAck  out  N_CH  one-cycle pulse: rate change applied
oBusy  out  1  a grant is pending (FSM not IDLE)
oRate  out  2*N_CH  currently applied rate code per channel
oDiv  out  N_CH  registered divided clock per channel
oStb  out  N_CH  one-cycle enable strobe per channel period

Behaviour:
- Reset (async, any time): cnt=0; rate[i]=RESET_RATE; oDiv=0, oStb=0, oAck=0, oBusy=0; FSM=IDLE; RR pointer=0; any in-flight grant is dropped without ack.
- Counter: if iSync, cnt<=0; else if iEn, cnt<=cnt+1 (wraps 15->0); else hold. wrap = iEn & ~iSync & (cnt==15).
- oDiv[i] <= cnt[rate[i]], one cycle of latency, 50% duty, period 2^(rate+1) cycles while iEn=1.
- oStb[i] <= iEn & ~iSync & (cnt[rate[i]:0] all ones). Exactly one strobe per oDiv period, coinciding with oDiv high for ÷2. No strobes while iEn=0.
- Arbiter: round robin over iReq. Search starts at the pointer, lowest index wins from there. After a grant, pointer <= granted+1 mod N_CH. Evaluated only in IDLE.
- FSM states:
  IDLE: if any iReq, latch gnt index and iRate slice -> WAIT, oBusy=1.
  WAIT: if iReq[gnt] drops -> IDLE with no change and no ack (abort). Else on wrap: rate[gnt]<=latched code, oAck[gnt]<=1 -> ACK.
  ACK: oAck pulse ends (exactly 1 cycle) -> IDLE. The requester must drop iReq on seeing oAck; if iReq is still high in IDLE, it is treated as a new request.
- Glitch-free rule: the new rate takes effect on the same edge as cnt 15->0. All oDiv are 1 at cnt=15 and become 0 at cnt=0, so the first new-rate cycle is a clean low phase.
- At most one channel change per wrap. Simultaneous requests are served over consecutive wraps in RR order.
- iSync while in WAIT: counter clears; the change waits for the next wrap. iEn=0 in WAIT: the change waits indefinitely.
- Requesting the rate already in effect: still full handshake, ack at wrap, no output disturbance.
- Rate codes are 2 bits, so there are no illegal values.

Decomposition:
- Package clk_div_pkg: rate code constants RATE_DIV2..RATE_DIV16 (2'd0..2'd3), CNT_W=4, CNT_MAX=4'hF, FSM state encoding (IDLE/WAIT/ACK).
- One sub-module, rr_arb: combinational N_CH round-robin arbiter (req, ptr -> one-hot gnt, index, valid). The top level holds the pointer register, counter, FSM and per-channel output registers.

Test Plan:
- Reset, then iEn=1, rates default 0 -> oDiv[0] high after edges 2,4,6…, oStb[0] pulses after edges 2,4,…; oRate=all 0, oAck=0.
- Ch1 iReq=1, iRate=3 at cnt=5 -> oBusy=1, no change until cnt 15->0 edge; oAck[1] 1 cycle; oRate[3:2]=3; oDiv[1] low 8 cycles / high 8 cycles, oStb[1] every 16 cycles; no runt on any oDiv.
- iReq=4'b1011 simultaneous, pointer=0 -> acks in order ch0, ch1, ch3 on three consecutive wraps (16 cycles apart).
- Ch2 request, then iReq[2] dropped at cnt=10 -> no oAck, oRate unchanged, FSM back to IDLE, next request accepted.
- iEn=0 during WAIT for 40 cycles -> cnt, oDiv frozen, oStb=0, no ack; ack on first wrap after iEn=1. iSync pulse -> cnt=0 next cycle and the wrap is delayed accordingly.
- reset asserted mid-WAIT -> immediately oBusy=0, oAck=0, all rates=RESET_RATE, cnt=0; after release, a held iReq is re-granted from pointer 0.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the divided-clock scheduler.
// Rate codes select which counter bit drives a channel's divided clock.
package clk_div_pkg;

  typedef logic [1:0] rate_t;

  localparam rate_t RATE_DIV2  = 2'd0;
  localparam rate_t RATE_DIV4  = 2'd1;
  localparam rate_t RATE_DIV8  = 2'd2;
  localparam rate_t RATE_DIV16 = 2'd3;

  localparam int unsigned      CNT_W   = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = 4'hF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  // Counter bits that must all be set on the last cycle of a channel period.
  function automatic logic [CNT_W-1:0] stb_mask(input rate_t rate);
    logic [CNT_W-1:0] mask;
    unique case (rate)
      RATE_DIV2:  mask = 4'b0001;
      RATE_DIV4:  mask = 4'b0011;
      RATE_DIV8:  mask = 4'b0111;
      RATE_DIV16: mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: searches upward from ptr (wrapping) and
// grants the first asserted request as both a one-hot vector and an index.
module rr_arb #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_CH-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    int j;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int k = 0; k < int'(N_CH); k++) begin
      j = int'(ptr) + k;
      if (j >= int'(N_CH)) begin
        j = j - int'(N_CH);
      end
      if (!valid && req[j]) begin
        valid  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/clk_div_sched.sv
// Central divided-clock scheduler: one shared divide counter feeding per-channel
// /2../16 clocks and strobes, with round-robin rate changes committed at counter wrap.
module clk_div_sched
  import clk_div_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter logic [1:0]  RESET_RATE = RATE_DIV2
) (
  input  logic              iClkIN,
  input  logic              reset,
  input  logic              iEn,
  input  logic              iSync,
  input  logic [N_CH-1:0]   iReq,
  input  logic [2*N_CH-1:0] iRate,
  output logic [N_CH-1:0]   oAck,
  output logic              oBusy,
  output logic [2*N_CH-1:0] oRate,
  output logic [N_CH-1:0]   oDiv,
  output logic [N_CH-1:0]   oStb
);

  localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [N_CH-1:0]  gnt_oh_q, gnt_oh_d;
  rate_t            code_q, code_d;

  rate_t [N_CH-1:0] rate_q, rate_d;
  logic [N_CH-1:0]  ack_q, ack_d;
  logic [N_CH-1:0]  div_q, div_d;
  logic [N_CH-1:0]  stb_q, stb_d;

  logic [N_CH-1:0]  arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_valid;

  rr_arb #(
    .N_CH  (N_CH),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (iReq),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign wrap = iEn & ~iSync & (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (iSync) begin
      cnt_d = '0;
    end else if (iEn) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Outputs sample the pre-edge counter with the pre-edge rate, so at a wrap
  // every channel ends high and the new rate starts on a clean low phase.
  always_comb begin
    div_d = '0;
    stb_d = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      div_d[i] = cnt_q[rate_q[i]];
      stb_d[i] = iEn & ~iSync & ((cnt_q & stb_mask(rate_q[i])) == stb_mask(rate_q[i]));
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_idx_d = gnt_idx_q;
    gnt_oh_d  = gnt_oh_q;
    code_d    = code_q;
    rate_d    = rate_q;
    ack_d     = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d   = ST_WAIT;
          gnt_idx_d = arb_idx;
          gnt_oh_d  = arb_gnt;
          code_d    = iRate[2*arb_idx +: 2];
          ptr_d     = (arb_idx == IDX_W'(N_CH - 1)) ? '0 : arb_idx + 1'b1;
        end
      end
      ST_WAIT: begin
        if ((iReq & gnt_oh_q) == '0) begin
          state_d = ST_IDLE;
        end else if (wrap) begin
          rate_d[gnt_idx_q] = code_q;
          ack_d             = gnt_oh_q;
          state_d           = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClkIN or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      gnt_idx_q <= '0;
      gnt_oh_q  <= '0;
      code_q    <= RATE_DIV2;
      rate_q    <= {N_CH{RESET_RATE}};
      ack_q     <= '0;
      div_q     <= '0;
      stb_q     <= '0;
    end else begin
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_oh_q  <= gnt_oh_d;
      code_q    <= code_d;
      rate_q    <= rate_d;
      ack_q     <= ack_d;
      div_q     <= div_d;
      stb_q     <= stb_d;
    end
  end

  assign oAck  = ack_q;
  assign oBusy = (state_q != ST_IDLE);
  assign oRate = rate_q;
  assign oDiv  = div_q;
  assign oStb  = stb_q;

endmodule

// File: tb/tb_clk_div_sched.sv
// Self-checking bench for clk_div_sched: directed scenarios plus random traffic,
// compared each cycle against a behavioural model of counter, rates and handshake.
module tb_clk_div_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       sync = 1'b0;
  logic [3:0] req = '0;
  logic [7:0] rate_in = '0;
  logic [3:0] ack;
  logic       busy;
  logic [7:0] rate_o;
  logic [3:0] div;
  logic [3:0] stb;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Behavioural model state
  int              m_cnt;
  logic [3:0][1:0] m_rate;
  logic [3:0]      m_div, m_stb, m_ack;
  logic            m_busy;
  int              m_owner;
  int              m_ptr;
  logic [1:0]      m_code;
  logic            m_inack;

  wire [20:0] dut_vec = {ack, busy, rate_o, div, stb};
  wire [20:0] mdl_vec = {m_ack, m_busy, m_rate, m_div, m_stb};

  clk_div_sched #(
    .N_CH       (4),
    .RESET_RATE (2'd0)
  ) dut (
    .iClkIN (clk),
    .reset  (reset),
    .iEn    (en),
    .iSync  (sync),
    .iReq   (req),
    .iRate  (rate_in),
    .oAck   (ack),
    .oBusy  (busy),
    .oRate  (rate_o),
    .oDiv   (div),
    .oStb   (stb)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_cnt   = 0;
    m_rate  = '0;
    m_div   = '0;
    m_stb   = '0;
    m_ack   = '0;
    m_busy  = 1'b0;
    m_owner = -1;
    m_ptr   = 0;
    m_code  = '0;
    m_inack = 1'b0;
  endtask

  // One clock edge of the specified behaviour, evaluated with pre-edge inputs.
  task automatic model_step();
    logic       wr;
    logic [3:0] nack;
    int         per, c;
    if (reset) begin
      model_reset();
      return;
    end
    wr = en && !sync && (m_cnt == 15);
    for (int i = 0; i < 4; i++) begin
      per      = 2 << m_rate[i];
      m_div[i] = ((m_cnt >> m_rate[i]) & 1) != 0;
      m_stb[i] = en && !sync && ((m_cnt % per) == per - 1);
    end
    nack = '0;
    if (m_inack) begin
      m_inack = 1'b0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        c = (m_ptr + k) % 4;
        if (m_owner < 0 && req[c]) begin
          m_owner = c;
          m_code  = rate_in[2*c +: 2];
          m_ptr   = (c + 1) % 4;
        end
      end
    end else if (!req[m_owner]) begin
      m_owner = -1;
    end else if (wr) begin
      m_rate[m_owner] = m_code;
      nack[m_owner]   = 1'b1;
      m_owner         = -1;
      m_inack         = 1'b1;
    end
    m_ack  = nack;
    m_busy = (m_owner >= 0) || m_inack;
    m_cnt  = sync ? 0 : (en ? (m_cnt + 1) % 16 : m_cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    model_reset();
    #2;
    checks++;
    if (dut_vec !== 21'd0) begin
      errors++; $display("FAIL reset_state: got %h expected 0", dut_vec);
    end
    tick();
    tick();
    en    = 1'b1;
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (div[0] !== (k % 2 == 0)) begin
        errors++; $display("FAIL reset_div0 edge %0d: got %b expected %b", k, div[0], (k % 2 == 0));
      end
      checks++;
      if (stb[0] !== (k % 2 == 0)) begin
        errors++; $display("FAIL reset_stb0 edge %0d: got %b expected %b", k, stb[0], (k % 2 == 0));
      end
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++; $display("FAIL reset_model @%0d: got %h expected %h", cyc, dut_vec, mdl_vec);
      end
    end
    checks++;
    if (rate_o !== 8'h00 || ack !== 4'h0) begin
      errors++; $display("FAIL reset_rate_ack: got rate=%h ack=%b expected 00/0000", rate_o, ack);
    end
  endtask

  task automatic test_rate_change();
    int ack_at = -1, hi = 0, st = 0, run = 0;
    logic last = 1'b0;
    for (int n = 0; n < 40 && m_cnt != 5; n++) tick();
    req[1]       = 1'b1;
    rate_in[3:2] = 2'd3;
    for (int k = 1; k <= 60; k++) begin
      tick();
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++; $display("FAIL rate_model @%0d: got %h expected %h", cyc, dut_vec, mdl_vec);
      end
      if (k == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++; $display("FAIL rate_busy: got %b expected 1", busy);
        end
      end
      if (ack[1] === 1'b1 && ack_at < 0) ack_at = k;
      if (m_ack[1]) req[1] = 1'b0;
      if (k >= 12 && k <= 43) begin
        hi += int'(div[1]);
        st += int'(stb[1]);
      end
      if (k == 12) begin
        last = div[1];
        run  = 1;
      end else if (k > 12) begin
        if (div[1] === last) run++;
        else begin
          checks++;
          if (run != 8) begin
            errors++; $display("FAIL rate_runlen edge %0d: got %0d expected 8", k, run);
          end
          run = 1;
        end
        last = div[1];
      end
    end
    checks++;
    if (ack_at != 11) begin
      errors++; $display("FAIL rate_ack_time: got %0d expected 11", ack_at);
    end
    checks++;
    if (hi != 16 || st != 2) begin
      errors++; $display("FAIL rate_div16_counts: got hi=%0d stb=%0d expected 16/2", hi, st);
    end
    checks++;
    if (rate_o[3:2] !== 2'd3) begin
      errors++; $display("FAIL rate_applied: got %0d expected 3", rate_o[3:2]);
    end
  endtask

  task automatic test_simultaneous();
    int         nacks = 0;
    int         order[3];
    int         at[3];
    logic [7:0] codes;
    reset = 1'b1;
    model_reset();
    tick();
    reset   = 1'b0;
    en      = 1'b1;
    codes   = 8'($urandom);
    rate_in = codes;
    req     = 4'b1011;
    for (int k = 1; k <= 80; k++) begin
      tick();
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++; $display("FAIL simul_model @%0d: got %h expected %h", cyc, dut_vec, mdl_vec);
      end
      for (int c = 0; c < 4; c++) begin
        if (ack[c] === 1'b1) begin
          if (nacks < 3) begin
            order[nacks] = c;
            at[nacks]    = k;
          end
          nacks++;
        end
      end
      req = req & ~m_ack;
    end
    checks++;
    if (nacks != 3) begin
      errors++; $display("FAIL simul_count: got %0d expected 3", nacks);
    end else begin
      checks++;
      if (order[0] != 0 || order[1] != 1 || order[2] != 3) begin
        errors++; $display("FAIL simul_order: got %0d,%0d,%0d expected 0,1,3", order[0], order[1], order[2]);
      end
      checks++;
      if (at[1] - at[0] != 16 || at[2] - at[1] != 16) begin
        errors++; $display("FAIL simul_spacing: got %0d,%0d expected 16,16", at[1] - at[0], at[2] - at[1]);
      end
    end
    checks++;
    if (rate_o !== {codes[7:6], 2'd0, codes[3:2], codes[1:0]}) begin
      errors++; $display("FAIL simul_rates: got %h expected %h", rate_o, {codes[7:6], 2'd0, codes[3:2], codes[1:0]});
    end
  endtask

  task automatic test_abort();
    logic [1:0] code0;
    logic       got = 1'b0;
    for (int n = 0; n < 40 && m_cnt != 2; n++) tick();
    rate_in[5:4] = 2'($urandom_range(1, 3));
    req[2]       = 1'b1;
    for (int n = 0; n < 20 && m_cnt != 10; n++) begin
      tick();
      checks++;
      if (busy !== 1'b1 || ack !== 4'h0) begin
        errors++; $display("FAIL abort_wait: got busy=%b ack=%b expected 1/0000", busy, ack);
      end
    end
    req[2] = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      checks++;
      if (ack !== 4'h0 || dut_vec !== mdl_vec) begin
        errors++; $display("FAIL abort_noack @%0d: got %h expected %h", cyc, dut_vec, mdl_vec);
      end
    end
    checks++;
    if (rate_o[5:4] !== 2'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_state: got rate=%0d busy=%b expected 0/0", rate_o[5:4], busy);
    end
    code0        = 2'($urandom_range(1, 3));
    rate_in[1:0] = code0;
    req[0]       = 1'b1;
    for (int n = 0; n < 40 && !got; n++) begin
      tick();
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++; $display("FAIL abort_next_model @%0d: got %h expected %h", cyc, dut_vec, mdl_vec);
      end
      if (ack[0] === 1'b1) got = 1'b1;
      req = req & ~m_ack;
    end
    checks++;
    if (!got || rate_o[1:0] !== code0) begin
      errors++; $display("FAIL abort_next: got ack=%b rate=%0d expected 1/%0d", got, rate_o[1:0], code0);
    end
  endtask

  task automatic test_enable_sync();
    logic [1:0] code3;
    logic [3:0] snap;
    int         ack_at = -1;
    for (int n = 0; n < 40 && m_cnt != 3; n++) tick();
    code3        = 2'($urandom_range(1, 3));
    rate_in[7:6] = code3;
    req[3]       = 1'b1;
    tick();
    tick();
    tick();
    en = 1'b0;
    tick();
    snap = div;
    for (int n = 0; n < 39; n++) begin
      tick();
      checks++;
      if (div !== snap || stb !== 4'h0 || ack !== 4'h0 || busy !== 1'b1) begin
        errors++; $display("FAIL frozen @%0d: got div=%b stb=%b ack=%b busy=%b expected %b/0000/0000/1",
                           cyc, div, stb, ack, busy, snap);
      end
    end
    en   = 1'b1;
    sync = 1'b1;
    tick();
    sync = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++; $display("FAIL sync_model @%0d: got %h expected %h", cyc, dut_vec, mdl_vec);
      end
      if (ack[3] === 1'b1 && ack_at < 0) ack_at = k;
      req = req & ~m_ack;
    end
    checks++;
    if (ack_at != 16) begin
      errors++; $display("FAIL sync_ack_time: got %0d expected 16", ack_at);
    end
    checks++;
    if (rate_o[7:6] !== code3) begin
      errors++; $display("FAIL sync_rate: got %0d expected %0d", rate_o[7:6], code3);
    end
  endtask

  task automatic test_reset_mid_wait();
    int first = -1;
    for (int n = 0; n < 40 && m_cnt != 2; n++) tick();
    rate_in = 8'($urandom) | 8'h55;
    req     = 4'b0010;
    tick();
    tick();
    req = 4'b0111;
    tick();
    #2 reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== 21'd0) begin
      errors++; $display("FAIL midwait_reset: got %h expected 0", dut_vec);
    end
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++; $display("FAIL midwait_model @%0d: got %h expected %h", cyc, dut_vec, mdl_vec);
      end
      for (int c = 3; c >= 0; c--) begin
        if (ack[c] === 1'b1 && first < 0) first = c;
      end
      req = req & ~m_ack;
    end
    checks++;
    if (first != 0) begin
      errors++; $display("FAIL midwait_first_grant: got %0d expected 0", first);
    end
  endtask

  task automatic test_random();
    logic [3:0] acked;
    for (int k = 0; k < 600; k++) begin
      tick();
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++; $display("FAIL random_model @%0d: got %h expected %h", cyc, dut_vec, mdl_vec);
      end
      acked = m_ack;
      req   = req & ~acked;
      for (int c = 0; c < 4; c++) begin
        if (!req[c] && !acked[c] && $urandom_range(0, 15) == 0) begin
          rate_in[2*c +: 2] = 2'($urandom);
          req[c]            = 1'b1;
        end else if (req[c] && $urandom_range(0, 199) == 0) begin
          req[c] = 1'b0;
        end
      end
      en   = ($urandom_range(0, 9) != 0);
      sync = ($urandom_range(0, 49) == 0);
    end
    en   = 1'b1;
    sync = 1'b0;
    req  = '0;
  endtask

  initial begin
    test_reset();
    test_rate_change();
    test_simultaneous();
    test_abort();
    test_enable_sync();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
